// File: rtl/retire_rrat.sv
// Retire stage and retirement RAT: pops the ROB head, frees superseded tags and
// replays the architectural map into the FRAT after a mispredict. Optional counters: RETIRE_STATS_EN.
module retire_rrat #(
  parameter int  NUM_ARCH     = 32,
  parameter int  NUM_PHYS     = 64,
  parameter int  RECOVER_BASE = 0,
  localparam int AW           = $clog2(NUM_ARCH),
  localparam int PW           = $clog2(NUM_PHYS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          STALL,
  input  logic          rob_valid,
  input  logic          rob_done,
  input  logic          rob_wr,
  input  logic [AW-1:0] rob_arch_dst,
  input  logic [PW-1:0] rob_phys_dst,
  input  logic          rob_mispredict,
  input  logic [31:0]   rob_target,
  output logic          rob_retire,
  output logic          rrat_free,
  output logic [PW-1:0] rrat_free_reg,
  output logic          FLUSH,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic          frat_restore_valid,
  output logic [AW-1:0] frat_restore_arch,
  output logic [PW-1:0] frat_restore_phys,
  output logic          recovering,
  output logic [31:0]   commit_count,
  output logic [31:0]   free_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FLUSH   = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [PW-1:0] rrat_q [NUM_ARCH];
  logic [PW-1:0] rrat_d [NUM_ARCH];
  logic          free_q, free_d;
  logic [PW-1:0] free_reg_q, free_reg_d;
  logic          flush_q, flush_d;
  logic          redir_valid_q, redir_valid_d;
  logic [31:0]   redir_pc_q, redir_pc_d;
  logic          restore_valid_q, restore_valid_d;
  logic [AW-1:0] restore_arch_q, restore_arch_d;
  logic [PW-1:0] restore_phys_q, restore_phys_d;
  logic          recovering_q, recovering_d;

  assign rob_retire = (state_q == S_IDLE) & rob_valid & rob_done & ~STALL & ~RESET;

  always_comb begin
    // NOTE: every _d starts from its _q (strobes from 0), so no branch can infer a latch.
    state_d         = state_q;
    idx_d           = idx_q;
    wcnt_d          = wcnt_q;
    rrat_d          = rrat_q;
    free_d          = 1'b0;
    free_reg_d      = free_reg_q;
    flush_d         = 1'b0;
    redir_valid_d   = 1'b0;
    redir_pc_d      = redir_pc_q;
    restore_valid_d = 1'b0;
    restore_arch_d  = restore_arch_q;
    restore_phys_d  = restore_phys_q;
    recovering_d    = recovering_q;

    case (state_q)
      S_IDLE: begin
        if (rob_retire) begin
          if (rob_wr) begin
            free_d = 1'b1;
            // Arch 0 is never mapped, so its own tag goes straight back.
            if (rob_arch_dst != '0) begin
              free_reg_d           = rrat_q[rob_arch_dst];
              rrat_d[rob_arch_dst] = rob_phys_dst;
            end else begin
              free_reg_d = rob_phys_dst;
            end
          end
          if (rob_mispredict) begin
            flush_d       = 1'b1;
            redir_valid_d = 1'b1;
            redir_pc_d    = rob_target;
            recovering_d  = 1'b1;
            state_d       = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!STALL) begin
          idx_d   = AW'(RECOVER_BASE);
          wcnt_d  = '0;
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (!STALL) begin
          if (wcnt_q == (AW+1)'(NUM_ARCH)) begin
            recovering_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            restore_valid_d = 1'b1;
            restore_arch_d  = idx_q;
            restore_phys_d  = rrat_q[idx_q];
            idx_d           = idx_q + 1'b1;
            wcnt_d          = wcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (RESET) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      wcnt_q          <= '0;
      // NOTE: the RRAT must reset to the identity map, so this array is reset flop by flop.
      for (int i = 0; i < NUM_ARCH; i++) rrat_q[i] <= PW'(i);
      free_q          <= 1'b0;
      free_reg_q      <= '0;
      flush_q         <= 1'b0;
      redir_valid_q   <= 1'b0;
      redir_pc_q      <= '0;
      restore_valid_q <= 1'b0;
      restore_arch_q  <= '0;
      restore_phys_q  <= '0;
      recovering_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      wcnt_q          <= wcnt_d;
      rrat_q          <= rrat_d;
      free_q          <= free_d;
      free_reg_q      <= free_reg_d;
      flush_q         <= flush_d;
      redir_valid_q   <= redir_valid_d;
      redir_pc_q      <= redir_pc_d;
      restore_valid_q <= restore_valid_d;
      restore_arch_q  <= restore_arch_d;
      restore_phys_q  <= restore_phys_d;
      recovering_q    <= recovering_d;
    end
  end

  assign rrat_free          = free_q;
  assign rrat_free_reg      = free_reg_q;
  assign FLUSH              = flush_q;
  assign redirect_valid     = redir_valid_q;
  assign redirect_pc        = redir_pc_q;
  assign frat_restore_valid = restore_valid_q;
  assign frat_restore_arch  = restore_arch_q;
  assign frat_restore_phys  = restore_phys_q;
  assign recovering         = recovering_q;

`ifdef RETIRE_STATS_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;
  logic [31:0] free_cnt_q, free_cnt_d;

  always_comb begin
    commit_cnt_d = commit_cnt_q + {31'd0, rob_retire};
    free_cnt_d   = free_cnt_q + {31'd0, free_d};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      commit_cnt_q <= '0;
      free_cnt_q   <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      free_cnt_q   <= free_cnt_d;
    end
  end

  assign commit_count = commit_cnt_q;
  assign free_count   = free_cnt_q;
`else
  assign commit_count = '0;
  assign free_count   = '0;
`endif

endmodule
